// File: rtl/fir_decim_out.sv
// Decimating output stage for task4_fir: block-average DECIM samples, scale, saturate, queue in a FIFO.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up instead of truncation.
module fir_decim_out #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_pulse,
    output logic                    overflow
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int SUM_W = IN_W + LOG2D;
    localparam int RES_W = SUM_W + 1;
    localparam int SH    = LOG2D + SHIFT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [LOG2D-1:0]        PH_LAST  = LOG2D'(DECIM - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic signed [RES_W-1:0] SAT_MAX  = RES_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_MIN  = ~SAT_MAX;
`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [RES_W-1:0] RND_HALF = RES_W'(1) << (SH - 1);
`endif

    // One guard bit above the block sum keeps the rounding offset from wrapping at +full-scale.
    function automatic logic signed [RES_W-1:0] scale(input logic signed [SUM_W-1:0] s);
        logic signed [RES_W-1:0] t;
        t = {s[SUM_W-1], s};
`ifdef FIR_DECIM_ROUND_EN
        t = t + RND_HALF;
`endif
        return t >>> SH;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RES_W-1:0] r);
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
    endfunction

    function automatic logic clipped(input logic signed [RES_W-1:0] r);
        return (r > SAT_MAX) || (r < SAT_MIN);
    endfunction

    logic [LOG2D-1:0]        phase_q, phase_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] y_ext, sum;
    logic signed [RES_W-1:0] res;
    logic signed [OUT_W-1:0] word;
    logic                    blk_done;

    logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d, count_after_pop;
    logic                    full, pop, push_ok;
    logic                    ovf_q, ovf_d;
    logic                    sat_q, sat_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;

    // Accumulate / scale stage
    always_comb begin
        y_ext    = {{LOG2D{y_in[IN_W-1]}}, y_in};
        sum      = acc_q + y_ext;
        res      = scale(sum);
        word     = saturate(res);
        phase_d  = phase_q;
        acc_d    = acc_q;
        blk_done = 1'b0;
        if (in_valid) begin
            phase_d  = phase_q + LOG2D'(1);
            acc_d    = (phase_q == '0) ? y_ext : sum;
            blk_done = (phase_q == PH_LAST);
        end
        sat_d = blk_done && clipped(res);
    end

    // FIFO control stage
    always_comb begin
        full            = (count_q == CNT_FULL);
        out_valid       = (count_q != '0);
        pop             = out_valid && out_ready;
        push_ok         = blk_done && (!full || pop);
        ovf_d           = ovf_q || (blk_done && full && !pop);
        wr_ptr_d        = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_after_pop = pop ? count_q - CNT_W'(1) : count_q;
        count_d         = push_ok ? count_after_pop + CNT_W'(1) : count_after_pop;
        // Head register: a word pushed into an (effectively) empty FIFO bypasses the memory.
        out_data_d      = out_data_q;
        if (push_ok && (count_after_pop == '0)) begin
            out_data_d = word;
        end else if (count_after_pop != '0) begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage is left unreset; count and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign out_data  = out_data_q;
    assign sat_pulse = sat_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Self-checking bench for fir_decim_out: directed scenarios plus random traffic against a queue-based model.
module tb_fir_decim_out;

    localparam int DECIM      = 4;
    localparam int SHIFT      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 1 << ($clog2(DECIM) + SHIFT);
`ifdef FIR_DECIM_ROUND_EN
    localparam int EXP_T2 = 1;
`else
    localparam int EXP_T2 = 0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic signed [15:0] y_in;
    logic signed [7:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sat_pulse;
    logic              overflow;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: block sum, position in block, and the queued words.
    int m_phase;
    int m_acc;
    int m_q[$];
    bit m_ovf;
    bit m_sat;
    int m_last;

    fir_decim_out dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .y_in     (y_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat_pulse(sat_pulse),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q--;
        return q;
    endfunction

    task automatic model_step(input bit r, input bit v, input int y, input bit rdy);
        bit pop;
        bit push;
        int w;
        if (r) begin
            m_phase = 0;
            m_acc   = 0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_sat   = 1'b0;
            m_last  = 0;
            return;
        end
        pop   = (m_q.size() > 0) && rdy;
        push  = 1'b0;
        m_sat = 1'b0;
        w     = 0;
        if (v) begin
            m_acc = (m_phase == 0) ? y : m_acc + y;
            if (m_phase == DECIM - 1) begin
`ifdef FIR_DECIM_ROUND_EN
                w = floor_div(m_acc + DIV / 2, DIV);
`else
                w = floor_div(m_acc, DIV);
`endif
                if (w > 127) begin
                    w = 127;
                    m_sat = 1'b1;
                end else if (w < -128) begin
                    w = -128;
                    m_sat = 1'b1;
                end
                push = 1'b1;
            end
            m_phase = (m_phase + 1) % DECIM;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input int y, input bit rdy);
        logic [7:0] e8;
        rst       = r;
        in_valid  = v;
        y_in      = 16'(y);
        out_ready = rdy;
        @(posedge clk);
        model_step(r, v, y, rdy);
        #1;
        e8 = m_last[7:0];
        chk("model_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
        chk("model_data", {24'b0, out_data}, {24'b0, e8});
        chk("model_sat", {31'b0, sat_pulse}, {31'b0, m_sat});
        chk("model_ovf", {31'b0, overflow}, {31'b0, m_ovf});
        @(negedge clk);
    endtask

    task automatic blk4(input int a, input int b, input int c, input int d, input bit rdy);
        cyc(1'b0, 1'b1, a, rdy);
        cyc(1'b0, 1'b1, b, rdy);
        cyc(1'b0, 1'b1, c, rdy);
        cyc(1'b0, 1'b1, d, rdy);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; y_in = '0; out_ready = 1'b0;
        m_phase = 0; m_acc = 0; m_ovf = 1'b0; m_sat = 1'b0; m_last = 0;

        // Reset state
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {24'b0, out_data}, 32'd0);
        chk("rst_sat", {31'b0, sat_pulse}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);

        // Basic average and one-cycle valid
        blk4(16, 32, 48, 64, 1'b1);
        chk("t1_data", {24'b0, out_data}, 32'd10);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_sat", {31'b0, sat_pulse}, 32'd0);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("t1_one_cycle", {31'b0, out_valid}, 32'd0);

        // Rounding vs truncation
        blk4(1, 2, 3, 4, 1'b1);
        chk("t2_pos", {24'b0, out_data}, 32'(EXP_T2 & 8'hFF));
        cyc(1'b0, 1'b0, 0, 1'b1);
        blk4(-1, -2, -3, -4, 1'b1);
        chk("t2_neg", {24'b0, out_data}, 32'h0FF);
        cyc(1'b0, 1'b0, 0, 1'b1);

        // Saturation at both rails
        blk4(32767, 32767, 32767, 32767, 1'b1);
        chk("t3_pos_data", {24'b0, out_data}, 32'd127);
        chk("t3_pos_sat", {31'b0, sat_pulse}, 32'd1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("t3_sat_pulse_width", {31'b0, sat_pulse}, 32'd0);
        blk4(-32768, -32768, -32768, -32768, 1'b1);
        chk("t3_neg_data", {24'b0, out_data}, 32'h080);
        chk("t3_neg_sat", {31'b0, sat_pulse}, 32'd1);
        cyc(1'b0, 1'b0, 0, 1'b1);

        // Fill, overflow, drain
        for (int k = 1; k <= 5; k++) begin
            blk4(4 * k, 4 * k, 4 * k, 4 * k, 1'b0);
            if (k == 4) chk("t4_no_ovf_yet", {31'b0, overflow}, 32'd0);
        end
        chk("t4_ovf", {31'b0, overflow}, 32'd1);
        chk("t4_head", {24'b0, out_data}, 32'd1);
        chk("t4_valid", {31'b0, out_valid}, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            cyc(1'b0, 1'b0, 0, 1'b1);
            chk("t4_drain", {24'b0, out_data}, 32'(k));
        end
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("t4_empty", {31'b0, out_valid}, 32'd0);
        chk("t4_ovf_sticky", {31'b0, overflow}, 32'd1);

        // Reset mid-block, then a gapped block
        cyc(1'b0, 1'b1, 16, 1'b1);
        cyc(1'b0, 1'b1, 32, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        chk("t6_ovf_clr", {31'b0, overflow}, 32'd0);
        chk("t6_valid_clr", {31'b0, out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 16, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b1, 32, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b1, 48, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("t6_no_early", {31'b0, out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 64, 1'b1);
        chk("t6_data", {24'b0, out_data}, 32'd10);
        chk("t6_valid", {31'b0, out_valid}, 32'd1);
        chk("t6_ovf", {31'b0, overflow}, 32'd0);

        // Simultaneous push and pop on a full FIFO
        cyc(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 4; k++) blk4(4 * k, 4 * k, 4 * k, 4 * k, 1'b0);
        cyc(1'b0, 1'b1, 20, 1'b0);
        cyc(1'b0, 1'b1, 20, 1'b0);
        cyc(1'b0, 1'b1, 20, 1'b0);
        cyc(1'b0, 1'b1, 20, 1'b1);
        chk("t5_head", {24'b0, out_data}, 32'd2);
        chk("t5_ovf", {31'b0, overflow}, 32'd0);
        for (int k = 3; k <= 5; k++) begin
            cyc(1'b0, 1'b0, 0, 1'b1);
            chk("t5_drain", {24'b0, out_data}, 32'(k));
        end
        cyc(1'b0, 1'b0, 0, 1'b1);
        chk("t5_empty", {31'b0, out_valid}, 32'd0);

        // Random traffic: first with a willing sink, then with a mostly stalled one
        for (int i = 0; i < 800; i++) begin
            bit r, v, rdy;
            int y;
            r   = ($urandom_range(99) == 0);
            v   = ($urandom_range(3) != 0);
            rdy = (i < 400) ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) y = int'($urandom_range(65535)) - 32768;
            else y = int'($urandom_range(200)) - 100;
            cyc(r, v, y, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
